// File: rtl/led_driver_pkg.sv
// Shared state encoding, word size and colour packing for the LED strip driver
// and its serial bit encoder.
package led_driver_pkg;

  localparam int BITS_PER_LED = 24;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SEND,
    ST_LATCH
  } drv_state_e;

  // WS2812B expects green first, then red, then blue, each byte MSB first.
  function automatic logic [BITS_PER_LED-1:0] pack_grb(input logic [7:0] green,
                                                       input logic [7:0] red,
                                                       input logic [7:0] blue);
    return {green, red, blue};
  endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// Shifts one 24-bit GRB word out as WS2812B NRZ pulses. A new word can be loaded
// in the word_done cycle so consecutive words run with no gap.
module ws2812_bit_encoder
  import led_driver_pkg::*;
#(
  parameter int BIT_CYCLES = 125,
  parameter int T0H_CYCLES = 40,
  parameter int T1H_CYCLES = 80,
  parameter int TIMER_W    = 13
) (
  input  logic                    clk_led,
  input  logic                    rst,
  input  logic                    load,
  input  logic [BITS_PER_LED-1:0] load_word,
  output logic                    strip_out,
  output logic                    word_done
);

  localparam logic [TIMER_W-1:0] BIT_LAST = TIMER_W'(BIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] T0H_T    = TIMER_W'(T0H_CYCLES);
  localparam logic [TIMER_W-1:0] T1H_T    = TIMER_W'(T1H_CYCLES);
  localparam logic [4:0]         LAST_BIT = 5'(BITS_PER_LED - 1);

  logic [BITS_PER_LED-1:0] shift_q, shift_d;
  logic [4:0]              bit_cnt_q, bit_cnt_d;
  logic [TIMER_W-1:0]      time_cnt_q, time_cnt_d;
  logic                    active_q, active_d;
  logic                    strip_q, strip_d;
  logic                    bit_end;
  logic [TIMER_W-1:0]      high_time;

  always_comb begin
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    time_cnt_d = time_cnt_q;
    active_d   = active_q;
    bit_end    = active_q && (time_cnt_q == BIT_LAST);
    word_done  = bit_end && (bit_cnt_q == LAST_BIT);

    if (load && (!active_q || word_done)) begin
      shift_d    = load_word;
      bit_cnt_d  = '0;
      time_cnt_d = '0;
      active_d   = 1'b1;
    end else if (bit_end) begin
      if (word_done) begin
        active_d   = 1'b0;
        bit_cnt_d  = '0;
        time_cnt_d = '0;
      end else begin
        shift_d    = {shift_q[BITS_PER_LED-2:0], 1'b0};
        bit_cnt_d  = bit_cnt_q + 5'd1;
        time_cnt_d = '0;
      end
    end else if (active_q) begin
      time_cnt_d = time_cnt_q + TIMER_W'(1);
    end

    // The output is registered from next-state values so each bit's high phase
    // starts on the same edge that selects the bit.
    high_time = shift_d[BITS_PER_LED-1] ? T1H_T : T0H_T;
    strip_d   = active_d && (time_cnt_d < high_time);
  end

  always_ff @(posedge clk_led or posedge rst) begin
    if (rst) begin
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      time_cnt_q <= '0;
      active_q   <= 1'b0;
      strip_q    <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      time_cnt_q <= time_cnt_d;
      active_q   <= active_d;
      strip_q    <= strip_d;
    end
  end

  assign strip_out = strip_q;

endmodule

// File: rtl/led_buffer_strip_driver.sv
// Reads LED colours from the colour buffer and streams a full WS2812B frame per
// request, prefetching the next LED while the current one shifts out.
module led_buffer_strip_driver
  import led_driver_pkg::*;
#(
  parameter int NUM_LEDS          = 50,
  parameter int LED_ADDRESS_WIDTH = 10,
  parameter int READ_LATENCY      = 2,
  parameter int BIT_CYCLES        = 125,
  parameter int T0H_CYCLES        = 40,
  parameter int T1H_CYCLES        = 80,
  parameter int RESET_CYCLES      = 6000
) (
  input  logic                         clk_led,
  input  logic                         rst,
  input  logic                         frame_start,
  output logic [LED_ADDRESS_WIDTH-1:0] next_led_request_address,
  input  logic [7:0]                   green_in,
  input  logic [7:0]                   red_in,
  input  logic [7:0]                   blue_in,
  output logic                         strip_out,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int MAX_TIME = (BIT_CYCLES > RESET_CYCLES) ? BIT_CYCLES : RESET_CYCLES;
  localparam int TIMER_W  = $clog2(MAX_TIME);
  localparam int LAT_W    = $clog2(READ_LATENCY + 2);
  localparam int AW       = LED_ADDRESS_WIDTH;

  localparam logic [AW-1:0]      LAST_IDX   = AW'(NUM_LEDS - 1);
  localparam logic [AW-1:0]      ADDR_ONE   = AW'(1);
  localparam logic [LAT_W-1:0]   RD_LAST    = LAT_W'(READ_LATENCY);
  localparam logic [TIMER_W-1:0] LATCH_LAST = TIMER_W'(RESET_CYCLES - 1);

  if (!(NUM_LEDS >= 1 && T0H_CYCLES < T1H_CYCLES && T1H_CYCLES < BIT_CYCLES &&
        READ_LATENCY < BITS_PER_LED * BIT_CYCLES)) begin : g_param_check
    $error("led_buffer_strip_driver: inconsistent timing parameters");
  end

  drv_state_e              state_q, state_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic [AW-1:0]           idx_q, idx_d;
  logic [AW-1:0]           idx_next;
  logic [LAT_W-1:0]        rd_cnt_q, rd_cnt_d;
  logic                    rd_pending_q, rd_pending_d;
  logic [BITS_PER_LED-1:0] stage_q, stage_d;
  logic [TIMER_W-1:0]      latch_cnt_q, latch_cnt_d;
  logic                    busy_q, busy_d;
  logic                    frame_done_q, frame_done_d;
  logic                    enc_load;
  logic [BITS_PER_LED-1:0] enc_word;
  logic                    enc_word_done;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    idx_d        = idx_q;
    idx_next     = idx_q + ADDR_ONE;
    rd_cnt_d     = rd_cnt_q;
    rd_pending_d = rd_pending_q;
    stage_d      = stage_q;
    latch_cnt_d  = latch_cnt_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    enc_load     = 1'b0;
    enc_word     = stage_q;

    unique case (state_q)
      ST_IDLE: begin
        // The frame_done cycle still counts as busy for request acceptance.
        if (frame_start && !frame_done_q) begin
          state_d  = ST_FETCH;
          busy_d   = 1'b1;
          addr_d   = '0;
          idx_d    = '0;
          rd_cnt_d = '0;
        end
      end

      ST_FETCH: begin
        if (rd_cnt_q == RD_LAST) begin
          enc_load = 1'b1;
          enc_word = pack_grb(green_in, red_in, blue_in);
          state_d  = ST_SEND;
          if (idx_q != LAST_IDX) begin
            addr_d       = idx_next;
            rd_pending_d = 1'b1;
            rd_cnt_d     = '0;
          end
        end else begin
          rd_cnt_d = rd_cnt_q + LAT_W'(1);
        end
      end

      ST_SEND: begin
        if (rd_pending_q) begin
          if (rd_cnt_q == RD_LAST) begin
            stage_d      = pack_grb(green_in, red_in, blue_in);
            rd_pending_d = 1'b0;
          end else begin
            rd_cnt_d = rd_cnt_q + LAT_W'(1);
          end
        end
        // Next LED is handed over on the last cycle of bit 23, keeping bit timing seamless.
        if (enc_word_done) begin
          if (idx_q == LAST_IDX) begin
            state_d     = ST_LATCH;
            latch_cnt_d = '0;
          end else begin
            enc_load = 1'b1;
            enc_word = stage_q;
            idx_d    = idx_next;
            if (idx_next != LAST_IDX) begin
              addr_d       = idx_next + ADDR_ONE;
              rd_pending_d = 1'b1;
              rd_cnt_d     = '0;
            end
          end
        end
      end

      ST_LATCH: begin
        if (latch_cnt_q == LATCH_LAST) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
          busy_d       = 1'b0;
          addr_d       = '0;
        end else begin
          latch_cnt_d = latch_cnt_q + TIMER_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_led or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      idx_q        <= '0;
      rd_cnt_q     <= '0;
      rd_pending_q <= 1'b0;
      stage_q      <= '0;
      latch_cnt_q  <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      idx_q        <= idx_d;
      rd_cnt_q     <= rd_cnt_d;
      rd_pending_q <= rd_pending_d;
      stage_q      <= stage_d;
      latch_cnt_q  <= latch_cnt_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  ws2812_bit_encoder #(
    .BIT_CYCLES (BIT_CYCLES),
    .T0H_CYCLES (T0H_CYCLES),
    .T1H_CYCLES (T1H_CYCLES),
    .TIMER_W    (TIMER_W)
  ) u_encoder (
    .clk_led   (clk_led),
    .rst       (rst),
    .load      (enc_load),
    .load_word (enc_word),
    .strip_out (strip_out),
    .word_done (enc_word_done)
  );

  assign next_led_request_address = addr_q;
  assign busy                     = busy_q;
  assign frame_done               = frame_done_q;

endmodule

// File: tb/tb_led_buffer_strip_driver.sv
// Self-checking bench: a 3-LED and a 1-LED driver are run against a frame-level
// waveform model computed from bit periods, pulse widths and latch length.
module tb_led_buffer_strip_driver;

  localparam int BIT_C      = 10;
  localparam int T0H        = 3;
  localparam int T1H        = 7;
  localparam int RESET_C    = 50;
  localparam int RL         = 2;
  localparam int BITS       = 24;
  localparam int FIRST_RISE = RL + 1;

  logic clk_led = 1'b0;
  logic rst;
  logic frame_start_a, frame_start_b;
  logic [9:0] addr_a, addr_b;
  logic [7:0] green_a, red_a, blue_a, green_b, red_b, blue_b;
  logic strip_a, busy_a, done_a, strip_b, busy_b, done_b;

  logic [23:0] mem_a [3];
  logic [23:0] mem_b;
  logic [9:0]  pipe_a1 = '0, pipe_a2 = '0, pipe_b1 = '0, pipe_b2 = '0;
  logic [23:0] rd_a, rd_b;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk_led = ~clk_led;

  // Registered colour buffer: data follows the address after RL clock edges.
  always @(posedge clk_led) begin
    pipe_a1 <= addr_a;
    pipe_a2 <= pipe_a1;
    pipe_b1 <= addr_b;
    pipe_b2 <= pipe_b1;
  end

  assign rd_a = (pipe_a2 < 10'd3) ? mem_a[pipe_a2[1:0]] : 24'h000000;
  assign rd_b = (pipe_b2 == 10'd0) ? mem_b : 24'h000000;
  assign {green_a, red_a, blue_a} = rd_a;
  assign {green_b, red_b, blue_b} = rd_b;

  led_buffer_strip_driver #(
    .NUM_LEDS(3), .LED_ADDRESS_WIDTH(10), .READ_LATENCY(RL), .BIT_CYCLES(BIT_C),
    .T0H_CYCLES(T0H), .T1H_CYCLES(T1H), .RESET_CYCLES(RESET_C)
  ) dut_a (
    .clk_led(clk_led), .rst(rst), .frame_start(frame_start_a),
    .next_led_request_address(addr_a), .green_in(green_a), .red_in(red_a),
    .blue_in(blue_a), .strip_out(strip_a), .busy(busy_a), .frame_done(done_a)
  );

  led_buffer_strip_driver #(
    .NUM_LEDS(1), .LED_ADDRESS_WIDTH(10), .READ_LATENCY(RL), .BIT_CYCLES(BIT_C),
    .T0H_CYCLES(T0H), .T1H_CYCLES(T1H), .RESET_CYCLES(RESET_C)
  ) dut_b (
    .clk_led(clk_led), .rst(rst), .frame_start(frame_start_b),
    .next_led_request_address(addr_b), .green_in(green_b), .red_in(red_b),
    .blue_in(blue_b), .strip_out(strip_b), .busy(busy_b), .frame_done(done_b)
  );

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Expected outputs t cycles after the edge that accepted frame_start.
  function automatic void modelAt(input bit sel, input int t, output logic e_strip,
                                  output logic e_busy, output logic e_done,
                                  output int e_addr);
    int n, send_end, latch_end, k, led, bitn, ph;
    logic [23:0] word;
    n         = sel ? 1 : 3;
    send_end  = FIRST_RISE + n * BITS * BIT_C;
    latch_end = send_end + RESET_C;
    e_busy    = (t >= 0) && (t < latch_end);
    e_done    = (t == latch_end);
    e_strip   = 1'b0;
    e_addr    = 0;
    if (t >= FIRST_RISE && t < send_end) begin
      k       = t - FIRST_RISE;
      led     = k / (BITS * BIT_C);
      bitn    = (k % (BITS * BIT_C)) / BIT_C;
      ph      = k % BIT_C;
      word    = sel ? mem_b : mem_a[led];
      e_strip = (ph < (word[23 - bitn] ? T1H : T0H));
      e_addr  = (led < n - 1) ? led + 1 : n - 1;
    end else if (t >= send_end && t < latch_end) begin
      e_addr = n - 1;
    end
  endfunction

  task automatic checkCycle(input bit sel, input int t);
    logic e_strip, e_busy, e_done;
    int   e_addr;
    string who;
    modelAt(sel, t, e_strip, e_busy, e_done, e_addr);
    who = sel ? "B" : "A";
    checkOutput($sformatf("%s.strip@%0d", who, t), 32'(sel ? strip_b : strip_a), 32'(e_strip));
    checkOutput($sformatf("%s.busy@%0d", who, t), 32'(sel ? busy_b : busy_a), 32'(e_busy));
    checkOutput($sformatf("%s.done@%0d", who, t), 32'(sel ? done_b : done_a), 32'(e_done));
    checkOutput($sformatf("%s.addr@%0d", who, t), 32'(sel ? addr_b : addr_a), e_addr);
  endtask

  // One accepted frame, with a stray request at spur_t and in the frame_done cycle.
  task automatic applyStimulus(input bit sel, input int extra, input int spur_t);
    int latch_end, first_rise, done_t, done_cnt;
    latch_end  = FIRST_RISE + (sel ? 1 : 3) * BITS * BIT_C + RESET_C;
    first_rise = -1;
    done_t     = -1;
    done_cnt   = 0;
    if (sel) frame_start_b = 1'b1; else frame_start_a = 1'b1;
    @(posedge clk_led); #1;
    for (int t = 0; t <= latch_end + extra; t++) begin
      if (t > 0) begin @(posedge clk_led); #1; end
      frame_start_a = 1'b0;
      frame_start_b = 1'b0;
      checkCycle(sel, t);
      if ((sel ? strip_b : strip_a) === 1'b1 && first_rise < 0) first_rise = t;
      if ((sel ? done_b : done_a) === 1'b1) begin
        done_cnt++;
        if (done_t < 0) done_t = t;
      end
      if (t == spur_t || t == latch_end) begin
        if (sel) frame_start_b = 1'b1; else frame_start_a = 1'b1;
      end
    end
    checkOutput("first_rise", first_rise, FIRST_RISE);
    checkOutput("done_cycle", done_t, latch_end);
    checkOutput("done_count", done_cnt, 1);
  endtask

  task automatic resetMidFrame(input int stop_t);
    frame_start_a = 1'b1;
    @(posedge clk_led); #1;
    for (int t = 0; t <= stop_t; t++) begin
      if (t > 0) begin @(posedge clk_led); #1; end
      frame_start_a = 1'b0;
      checkCycle(1'b0, t);
    end
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_strip", 32'(strip_a), 0);
    checkOutput("rst_busy", 32'(busy_a), 0);
    checkOutput("rst_addr", 32'(addr_a), 0);
    checkOutput("rst_done", 32'(done_a), 0);
    repeat (3) @(posedge clk_led);
    #1 rst = 1'b0;
    for (int i = 0; i < RESET_C + 20; i++) begin
      @(posedge clk_led); #1;
      checkOutput("post_rst_done", 32'(done_a), 0);
      checkOutput("post_rst_strip", 32'(strip_a), 0);
      checkOutput("post_rst_busy", 32'(busy_a), 0);
    end
  endtask

  task automatic loadSpecColours();
    mem_a[0] = 24'hFF0081;
    mem_a[1] = 24'h00A501;
    mem_a[2] = 24'h8000FF;
    mem_b    = 24'h010203;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    frame_start_a = 1'b0;
    frame_start_b = 1'b0;
    rst = 1'b0;
    loadSpecColours();
    #1 rst = 1'b1;
    #1;
    checkOutput("reset_strip_a", 32'(strip_a), 0);
    checkOutput("reset_busy_a", 32'(busy_a), 0);
    checkOutput("reset_done_a", 32'(done_a), 0);
    checkOutput("reset_addr_a", 32'(addr_a), 0);
    checkOutput("reset_strip_b", 32'(strip_b), 0);
    checkOutput("reset_busy_b", 32'(busy_b), 0);
    checkOutput("reset_done_b", 32'(done_b), 0);
    checkOutput("reset_addr_b", 32'(addr_b), 0);
    repeat (3) @(posedge clk_led);
    #1 rst = 1'b0;
    @(posedge clk_led); #1;

    applyStimulus(1'b0, 1, $urandom_range(700, 10));
    applyStimulus(1'b0, 1, $urandom_range(700, 10));
    applyStimulus(1'b1, 2, -1);

    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 3; i++) mem_a[i] = 24'($urandom);
      applyStimulus(1'b0, $urandom_range(6, 1), $urandom_range(770, 5));
    end
    mem_b = 24'($urandom);
    applyStimulus(1'b1, 3, $urandom_range(290, 5));

    loadSpecColours();
    resetMidFrame($urandom_range(482, 243));
    applyStimulus(1'b0, 1, -1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
